rs_syndrome_ctrl: RTL and testbench
===================================

RS_SYNDROME_CTRL -- requirements
Module: rs_syndrome_ctrl

Interface
REQ-001 SHALL have parameter N, default 204, codeword length in symbols (RS(204,188)); legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 In_Valid  in  1  received symbol present on the Syndrom input bus.
REQ-006 In_Sop  in  1  start-of-codeword marker, qualified by In_Valid.
REQ-007 In_Ready  out  1  controller accepts a symbol this cycle.
REQ-008 Syn_En  out  1  Syndrom accumulator enable (symbol accepted).
REQ-009 Syn_Clr  out  1  Syndrom loads the symbol instead of accumulating (first symbol).
REQ-010 Syn_Last  out  1  accepted symbol is index N-1.
REQ-011 Sym_Idx  out  8  index of the next symbol expected (0..N-1).
REQ-012 Zero_Syn  in  1  all 16 syndromes S1..S16 are zero.
REQ-013 Out_Valid  out  1  syndromes final and held for the downstream solver.
REQ-014 Out_Ready  in  1  downstream accepts the syndrome set.
REQ-015 Err_Free  out  1  Out_Valid AND Zero_Syn.
REQ-016 Cw_Cnt  out  CNT_W  codewords handed off; Err_Cnt  out  CNT_W  handed-off codewords with Zero_Syn=0.
REQ-017 Sync_Err  out  1  one-cycle pulse: In_Sop seen mid-codeword.

Function
REQ-018 SHALL implement FSM IDLE, ACCUM, OUT; accept = In_Valid AND In_Ready.
REQ-019 In_Ready SHALL be 1 in IDLE and ACCUM, and in OUT only when Out_Ready=1.
REQ-020 IDLE: accept without In_Sop SHALL be discarded (Syn_En=0); accept with In_Sop SHALL assert Syn_En and Syn_Clr, set Sym_Idx=1, go ACCUM.
REQ-021 ACCUM: each accept SHALL assert Syn_En and increment Sym_Idx; In_Valid=0 SHALL stall with Sym_Idx held and Syn_En=0.
REQ-022 ACCUM accept at Sym_Idx=N-1 SHALL assert Syn_Last, wrap Sym_Idx to 0, and go OUT; Out_Valid SHALL rise the next cycle (latency 1 from last symbol).
REQ-023 OUT: Out_Valid SHALL stay 1, Syn_En 0, syndromes untouched, until Out_Ready=1.
REQ-024 OUT with Out_Ready=1: Cw_Cnt SHALL increment; Err_Cnt SHALL increment if Zero_Syn=0; both saturate at all-ones.
REQ-025 OUT with Out_Ready=1 and accepted In_Sop in the same cycle SHALL go directly to ACCUM with Syn_Clr=1 (no bubble); otherwise go IDLE.
REQ-026 Syn_En, Syn_Clr, Syn_Last, In_Ready, Err_Free SHALL be combinational from state and inputs; all others registered.
REQ-027 In_Sop in ACCUM SHALL be handled per REQ-031/REQ-032.

Reset
REQ-028 Reset low SHALL immediately force IDLE, Sym_Idx=0, Out_Valid=0, Cw_Cnt=0, Err_Cnt=0, Sync_Err=0.
REQ-029 While Reset low, In_Ready, Syn_En, Syn_Clr, Syn_Last, Err_Free SHALL be 0.
REQ-030 Reset mid-codeword SHALL abandon the partial codeword; counters do not count it.

Configuration
REQ-031 With RS_SOP_RESYNC_EN defined: In_Sop accepted in ACCUM SHALL restart the codeword (Syn_Clr=1, Sym_Idx=1) and pulse Sync_Err next cycle.
REQ-032 Without RS_SOP_RESYNC_EN: In_Sop in ACCUM SHALL be ignored (symbol accumulated normally); Sync_Err tied 0.

Structure
REQ-033 State encoding, N default and CNT_W default SHALL live in shared package rs_dec_pkg.
REQ-034 Saturating counter SHALL be sub-module rs_sat_cnt, instantiated twice; no other sub-modules.

Verification
REQ-035 Reset low 0-7 ns, In_Valid=0 -> all outputs 0; after release In_Ready=1, no Syn_En.
REQ-036 204 continuous symbols, In_Sop on first, Zero_Syn=1, Out_Ready=1 -> Syn_Clr only on symbol 0, Syn_Last on 203, Out_Valid one cycle later, Err_Free=1, Cw_Cnt=1, Err_Cnt=0.
REQ-037 Out_Ready held 0 for 10 cycles in OUT, Zero_Syn=0 -> Out_Valid held, In_Ready=0, Syn_En=0; on release Err_Cnt=1.
REQ-038 Back-to-back codewords, In_Sop in the Out_Ready cycle -> Syn_Clr same cycle, no idle gap, Cw_Cnt=2 after second.
REQ-039 In_Sop at Sym_Idx=100 -> with macro Sync_Err pulse and Sym_Idx=1; without, Sym_Idx=101, Sync_Err=0.
REQ-040 Reset low at Sym_Idx=50 -> outputs 0 immediately; new In_Sop after release starts cleanly, Cw_Cnt=0.

Source files
------------

// File: rtl/rs_dec_pkg.sv
// Shared definitions for the RS(204,188) decoder front end: controller state
// encoding, default codeword length and statistics counter width.
package rs_dec_pkg;

  localparam int unsigned RS_N_DEF     = 204;
  localparam int unsigned RS_CNT_W_DEF = 16;
  localparam int unsigned SYM_IDX_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } rs_state_e;

endpackage

// File: rtl/rs_sat_cnt.sv
// Saturating up-counter used for the codeword statistics.
module rs_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/rs_syndrome_ctrl.sv
// Syndrome accumulation controller: frames N-symbol codewords, drives the
// syndrome accumulator and hands off the syndrome set. Option: RS_SOP_RESYNC_EN.
module rs_syndrome_ctrl
  import rs_dec_pkg::*;
#(
  parameter int unsigned N     = RS_N_DEF,
  parameter int unsigned CNT_W = RS_CNT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 In_Valid,
  input  logic                 In_Sop,
  output logic                 In_Ready,
  output logic                 Syn_En,
  output logic                 Syn_Clr,
  output logic                 Syn_Last,
  output logic [SYM_IDX_W-1:0] Sym_Idx,
  input  logic                 Zero_Syn,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic                 Err_Free,
  output logic [CNT_W-1:0]     Cw_Cnt,
  output logic [CNT_W-1:0]     Err_Cnt,
  output logic                 Sync_Err
);

  localparam logic [SYM_IDX_W-1:0] LAST_IDX = SYM_IDX_W'(N - 1);

  rs_state_e             state_q, state_d;
  logic [SYM_IDX_W-1:0]  idx_d;
  logic                  handoff;
`ifdef RS_SOP_RESYNC_EN
  logic                  sync_err_d;
`endif

  // State, index and hand-off flag registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      Sym_Idx   <= '0;
      Out_Valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      Sym_Idx   <= idx_d;
      Out_Valid <= (state_d == ST_OUT);
    end
  end

`ifdef RS_SOP_RESYNC_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Sync_Err <= 1'b0;
    end else begin
      Sync_Err <= sync_err_d;
    end
  end
`else
  assign Sync_Err = 1'b0;
`endif

  // Next-state and accumulator control; everything held low during reset
  always_comb begin
    state_d  = state_q;
    idx_d    = Sym_Idx;
    In_Ready = 1'b0;
    Syn_En   = 1'b0;
    Syn_Clr  = 1'b0;
    Syn_Last = 1'b0;
    handoff  = 1'b0;
`ifdef RS_SOP_RESYNC_EN
    sync_err_d = 1'b0;
`endif
    if (Reset) begin
      case (state_q)
        ST_IDLE: begin
          In_Ready = 1'b1;
          if (In_Valid && In_Sop) begin
            Syn_En  = 1'b1;
            Syn_Clr = 1'b1;
            idx_d   = SYM_IDX_W'(1);
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          In_Ready = 1'b1;
          if (In_Valid) begin
            Syn_En = 1'b1;
`ifdef RS_SOP_RESYNC_EN
            if (In_Sop) begin
              Syn_Clr    = 1'b1;
              idx_d      = SYM_IDX_W'(1);
              sync_err_d = 1'b1;
            end else
`endif
            if (Sym_Idx == LAST_IDX) begin
              Syn_Last = 1'b1;
              idx_d    = '0;
              state_d  = ST_OUT;
            end else begin
              idx_d = Sym_Idx + SYM_IDX_W'(1);
            end
          end
        end
        ST_OUT: begin
          In_Ready = Out_Ready;
          if (Out_Ready) begin
            handoff = 1'b1;
            // A new start-of-codeword in the hand-off cycle starts with no bubble
            if (In_Valid && In_Sop) begin
              Syn_En  = 1'b1;
              Syn_Clr = 1'b1;
              idx_d   = SYM_IDX_W'(1);
              state_d = ST_ACCUM;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign Err_Free = Reset & Out_Valid & Zero_Syn;

  rs_sat_cnt #(.W(CNT_W)) u_cw_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (handoff),
    .Count (Cw_Cnt)
  );

  rs_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (handoff & ~Zero_Syn),
    .Count (Err_Cnt)
  );

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Directed self-checking bench for rs_syndrome_ctrl (N=204, CNT_W=16).
module tb_rs_syndrome_ctrl;

  logic        Clk;
  logic        Reset;
  logic        In_Valid;
  logic        In_Sop;
  logic        In_Ready;
  logic        Syn_En;
  logic        Syn_Clr;
  logic        Syn_Last;
  logic [7:0]  Sym_Idx;
  logic        Zero_Syn;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Err_Free;
  logic [15:0] Cw_Cnt;
  logic [15:0] Err_Cnt;
  logic        Sync_Err;

  int n_assert = 0;
  int n_fail   = 0;

  rs_syndrome_ctrl #(.N(204), .CNT_W(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Sop    (In_Sop),
    .In_Ready  (In_Ready),
    .Syn_En    (Syn_En),
    .Syn_Clr   (Syn_Clr),
    .Syn_Last  (Syn_Last),
    .Sym_Idx   (Sym_Idx),
    .Zero_Syn  (Zero_Syn),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Err_Free  (Err_Free),
    .Cw_Cnt    (Cw_Cnt),
    .Err_Cnt   (Err_Cnt),
    .Sync_Err  (Sync_Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Feed n consecutive symbols, start marker optionally on the first
  task automatic send(input int n, input bit first_sop);
    for (int i = 0; i < n; i++) begin
      In_Valid = 1'b1;
      In_Sop   = first_sop && (i == 0);
      tick();
    end
    In_Valid = 1'b0;
    In_Sop   = 1'b0;
  endtask

  initial begin
    Reset     = 1'b0;
    In_Valid  = 1'b0;
    In_Sop    = 1'b0;
    Zero_Syn  = 1'b1;
    Out_Ready = 1'b1;

    // Reset state
    #3;
    chk("rst_in_ready",  In_Ready,  0);
    chk("rst_syn_en",    Syn_En,    0);
    chk("rst_syn_clr",   Syn_Clr,   0);
    chk("rst_syn_last",  Syn_Last,  0);
    chk("rst_sym_idx",   Sym_Idx,   0);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_err_free",  Err_Free,  0);
    chk("rst_cw_cnt",    Cw_Cnt,    0);
    chk("rst_err_cnt",   Err_Cnt,   0);
    chk("rst_sync_err",  Sync_Err,  0);
    #4 Reset = 1'b1;
    #1;
    chk("rel_in_ready", In_Ready, 1);
    chk("rel_syn_en",   Syn_En,   0);
    tick();

    // IDLE discards a symbol without start marker
    In_Valid = 1'b1;
    In_Sop   = 1'b0;
    #1;
    chk("idle_in_ready", In_Ready, 1);
    chk("idle_syn_en",   Syn_En,   0);
    tick();
    In_Valid = 1'b0;
    chk("idle_sym_idx", Sym_Idx, 0);

    // Codeword 1: continuous, error free, downstream ready
    for (int i = 0; i < 204; i++) begin
      In_Valid = 1'b1;
      In_Sop   = (i == 0);
      #1;
      chk("cw1_syn_en",   Syn_En,   1);
      chk("cw1_syn_clr",  Syn_Clr,  (i == 0) ? 1 : 0);
      chk("cw1_syn_last", Syn_Last, (i == 203) ? 1 : 0);
      chk("cw1_sym_idx",  Sym_Idx,  i);
      if (i == 203) chk("cw1_ov_before", Out_Valid, 0);
      tick();
    end
    In_Valid = 1'b0;
    In_Sop   = 1'b0;
    #1;
    chk("cw1_out_valid", Out_Valid, 1);
    chk("cw1_err_free",  Err_Free,  1);
    chk("cw1_idx_wrap",  Sym_Idx,   0);
    chk("cw1_syn_en_out", Syn_En,   0);
    tick();
    chk("cw1_cw_cnt",  Cw_Cnt,    1);
    chk("cw1_err_cnt", Err_Cnt,   0);
    chk("cw1_ov_drop", Out_Valid, 0);

    // Codeword 2: syndromes nonzero, downstream stalls 10 cycles
    Zero_Syn  = 1'b0;
    Out_Ready = 1'b0;
    send(204, 1'b1);
    for (int i = 0; i < 10; i++) begin
      In_Valid = 1'b1;
      #1;
      chk("stall_out_valid", Out_Valid, 1);
      chk("stall_in_ready",  In_Ready,  0);
      chk("stall_syn_en",    Syn_En,    0);
      chk("stall_err_free",  Err_Free,  0);
      chk("stall_err_cnt",   Err_Cnt,   0);
      tick();
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    #1;
    chk("stall_rel_ready", In_Ready, 1);
    tick();
    chk("cw2_err_cnt", Err_Cnt, 1);
    chk("cw2_cw_cnt",  Cw_Cnt,  2);

    // Codewords 3 and 4 back to back
    Zero_Syn = 1'b1;
    send(204, 1'b1);
    In_Valid = 1'b1;
    In_Sop   = 1'b1;
    #1;
    chk("b2b_out_valid", Out_Valid, 1);
    chk("b2b_in_ready",  In_Ready,  1);
    chk("b2b_syn_en",    Syn_En,    1);
    chk("b2b_syn_clr",   Syn_Clr,   1);
    tick();
    In_Sop = 1'b0;
    chk("b2b_cw_cnt",  Cw_Cnt,    3);
    chk("b2b_sym_idx", Sym_Idx,   1);
    chk("b2b_ov_low",  Out_Valid, 0);
    send(203, 1'b0);
    chk("cw4_out_valid", Out_Valid, 1);
    tick();
    chk("cw4_cw_cnt",  Cw_Cnt,  4);
    chk("cw4_err_cnt", Err_Cnt, 1);

    // Start marker in the middle of a codeword
    send(100, 1'b1);
    In_Valid = 1'b1;
    In_Sop   = 1'b1;
    #1;
    chk("mid_sym_idx", Sym_Idx, 100);
    chk("mid_syn_en",  Syn_En,  1);
`ifdef RS_SOP_RESYNC_EN
    chk("mid_syn_clr", Syn_Clr, 1);
`else
    chk("mid_syn_clr", Syn_Clr, 0);
`endif
    tick();
    In_Valid = 1'b0;
    In_Sop   = 1'b0;
`ifdef RS_SOP_RESYNC_EN
    chk("mid_idx_after", Sym_Idx,  1);
    chk("mid_sync_err",  Sync_Err, 1);
`else
    chk("mid_idx_after", Sym_Idx,  101);
    chk("mid_sync_err",  Sync_Err, 0);
`endif
    tick();
    chk("mid_sync_err_end", Sync_Err, 0);
`ifdef RS_SOP_RESYNC_EN
    chk("mid_stall_idx", Sym_Idx, 1);
    send(203, 1'b0);
`else
    chk("mid_stall_idx", Sym_Idx, 101);
    send(103, 1'b0);
`endif
    chk("mid_out_valid", Out_Valid, 1);
    tick();
    chk("mid_cw_cnt", Cw_Cnt, 5);

    // Reset in the middle of a codeword
    send(50, 1'b1);
    chk("pre_rst_idx", Sym_Idx, 50);
    Reset    = 1'b0;
    In_Valid = 1'b1;
    #1;
    chk("mrst_sym_idx",   Sym_Idx,   0);
    chk("mrst_in_ready",  In_Ready,  0);
    chk("mrst_syn_en",    Syn_En,    0);
    chk("mrst_out_valid", Out_Valid, 0);
    chk("mrst_cw_cnt",    Cw_Cnt,    0);
    chk("mrst_err_cnt",   Err_Cnt,   0);
    chk("mrst_sync_err",  Sync_Err,  0);
    #2 Reset = 1'b1;
    In_Valid = 1'b0;
    tick();
    Zero_Syn = 1'b0;
    In_Valid = 1'b1;
    In_Sop   = 1'b1;
    #1;
    chk("post_syn_clr", Syn_Clr, 1);
    chk("post_sym_idx", Sym_Idx, 0);
    chk("post_cw_cnt",  Cw_Cnt,  0);
    tick();
    In_Sop = 1'b0;
    send(203, 1'b0);
    chk("post_out_valid", Out_Valid, 1);
    tick();
    chk("post_cw_cnt_end",  Cw_Cnt,  1);
    chk("post_err_cnt_end", Err_Cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
